// File: rtl/bernoulli_enc_pkg.sv
// bernoulli_enc_pkg: FSM states, Galois LFSR tap masks and refractory counter sizing
package bernoulli_enc_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, LAST, HOLD, FIN} state_t;
  localparam logic [31:0] LFSR_TAPS_8 = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] lfsr_taps(input int width);
    return width == 8 ? LFSR_TAPS_8 : width == 16 ? LFSR_TAPS_16 : LFSR_TAPS_32;
  endfunction
  function automatic int refract_width(input int steps);
    return steps < 1 ? 1 : $clog2(steps + 1);
  endfunction
endpackage

// File: rtl/bernoulli_spike_encoder_seq_lfsr.sv
// lfsr_step: right-shifting Galois LFSR, advances when i_en, reloads SEED on rst
module lfsr_step #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED = '1,
  parameter logic [WIDTH-1:0] TAPS = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_rnd
);
  logic [WIDTH-1:0] r_lfsr;
  always_ff @(posedge clk)
    if (rst) r_lfsr <= SEED;
    else if (i_en) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign o_rnd = r_lfsr;
endmodule

// File: rtl/bernoulli_spike_encoder_seq.sv
// bernoulli_spike_encoder_seq: time-multiplexed Bernoulli spike encoder, one channel per clock.
// Optional per-channel refractory counters are enabled with `define REFRACTORY_EN.
module bernoulli_spike_encoder_seq
  import bernoulli_enc_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int PROB_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STEP_WIDTH = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  parameter logic [31:0] PROB_INIT = 32'h7FFF_FFFF,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [STEP_WIDTH-1:0]   num_steps,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_wen,
  input  logic [PROB_WIDTH-1:0]   mem_data_in,
  output logic [PROB_WIDTH-1:0]   mem_data_out,
  output logic [NUM_CHANNELS-1:0] spikes,
  output logic                    spikes_valid,
  input  logic                    spikes_ready,
  output logic [STEP_WIDTH-1:0]   step_count,
  output logic                    busy,
  output logic                    done
);
  localparam int CW = $clog2(NUM_CHANNELS);
  state_t r_state;
  logic [PROB_WIDTH-1:0] r_mem [NUM_CHANNELS] = '{default: PROB_INIT[PROB_WIDTH-1:0]};
  logic [PROB_WIDTH-1:0] r_rd, w_rnd;
  logic [CW-1:0] r_ch, r_ev_idx;
  logic [NUM_CHANNELS-1:0] r_shadow, w_vec;
  logic [STEP_WIDTH-1:0] w_step_inc;
  logic r_ev, r_stop, w_fire, w_hs, w_last_step, w_host_ok;
  assign w_host_ok = {1'b0, mem_addr} < (ADDR_WIDTH + 1)'(NUM_CHANNELS);
  always_ff @(posedge clk) begin
    if (mem_wen && w_host_ok) r_mem[mem_addr[CW-1:0]] <= mem_data_in;
    mem_data_out <= rst || !w_host_ok ? '0 : r_mem[mem_addr[CW-1:0]];
  end
  lfsr_step #(
    .WIDTH(PROB_WIDTH),
    .SEED(LFSR_SEED[PROB_WIDTH-1:0]),
    .TAPS(PROB_WIDTH'(lfsr_taps(PROB_WIDTH)))
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .i_en(r_ev),
    .o_rnd(w_rnd)
  );
`ifdef REFRACTORY_EN
  localparam int RW = refract_width(REFRACT_STEPS);
  logic [RW-1:0] r_ref [NUM_CHANNELS];
  assign w_fire = r_rd > w_rnd && r_ref[r_ev_idx] == '0;
  // a channel's own firing step does not count towards its refractory period
  always_ff @(posedge clk)
    if (rst || (r_state == IDLE && start)) r_ref <= '{default: '0};
    else if (w_hs) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (!spikes[i] && r_ref[i] != '0) r_ref[i] <= r_ref[i] - 1'b1;
    end else if (r_ev && w_fire) r_ref[r_ev_idx] <= RW'(REFRACT_STEPS);
`else
  assign w_fire = r_rd > w_rnd;
`endif
  always_comb begin
    w_vec = r_shadow;
    w_vec[r_ev_idx] = w_fire;
  end
  assign w_hs = spikes_valid && spikes_ready;
  assign w_step_inc = step_count + 1'b1;
  assign w_last_step = (num_steps != '0 && w_step_inc == num_steps) || r_stop || stop;
  assign busy = r_state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ch <= '0;
      r_ev <= 1'b0;
      r_ev_idx <= '0;
      r_rd <= '0;
      r_shadow <= '0;
      r_stop <= 1'b0;
      spikes <= '0;
      spikes_valid <= 1'b0;
      step_count <= '0;
      done <= 1'b0;
    end else begin
      r_ev <= r_state == SCAN;
      r_ev_idx <= r_ch;
      r_rd <= r_mem[r_ch];
      r_stop <= r_state == IDLE ? start && stop : r_state == FIN ? 1'b0 : r_stop || stop;
      done <= 1'b0;
      if (r_ev) r_shadow <= w_vec;
      case (r_state)
        IDLE: if (start) begin
          step_count <= '0;
          r_ch <= '0;
          r_state <= SCAN;
        end
        SCAN: begin
          r_ch <= r_ch + 1'b1;
          if (r_ch == CW'(NUM_CHANNELS - 1)) r_state <= LAST;
        end
        LAST: begin
          spikes <= w_vec;
          spikes_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: if (w_hs) begin
          spikes_valid <= 1'b0;
          step_count <= w_step_inc;
          r_ch <= '0;
          done <= w_last_step;
          r_state <= w_last_step ? FIN : SCAN;
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bernoulli_spike_encoder_seq.sv
// tb_bernoulli_spike_encoder_seq: directed checks of the Bernoulli spike encoder
module tb_bernoulli_spike_encoder_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, mem_wen = 1'b0, spikes_ready = 1'b0;
  logic [15:0] num_steps = '0, step_count;
  logic [7:0] mem_addr = '0;
  logic [31:0] mem_data_in = '0, mem_data_out, spikes;
  logic spikes_valid, busy, done;
  int vectors = 0, miscompares = 0;
  int hs, dones, first_cyc, period, fires[32];
  logic tmo;
  logic [31:0] acc_or, first_vec;

  bernoulli_spike_encoder_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_steps(num_steps),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .spikes(spikes), .spikes_valid(spikes_valid),
    .spikes_ready(spikes_ready), .step_count(step_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_vec();
    logic [31:0] s, v, p;
    s = 32'hACE1_0001;
    v = '0;
    for (int c = 0; c < 32; c++) begin
      p = 32'(c) * 32'h0800_0000;
      v[c] = p > s;
      s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    end
    return v;
  endfunction

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_wen = 1'b1; mem_data_in = d;
    @(negedge clk);
    mem_wen = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_addr = a; mem_wen = 1'b0;
    @(negedge clk);
    d = mem_data_out;
  endtask

  task automatic run(input logic [15:0] n, input int stop_hs, input int budget);
    int cyc, since;
    hs = 0; dones = 0; first_cyc = -1; period = -1; tmo = 1'b0;
    acc_or = '0; first_vec = '0; since = 0; cyc = 0;
    foreach (fires[i]) fires[i] = 0;
    @(negedge clk);
    num_steps = n; spikes_ready = 1'b1; start = 1'b1;
    forever begin
      @(negedge clk);
      start = 1'b0; cyc++; since++;
      stop = stop_hs >= 0 && hs == stop_hs && since == 10;
      if (done) dones++;
      if (spikes_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        else if (period < 0) period = cyc - first_cyc;
        if (hs == 0) first_vec = spikes;
        acc_or |= spikes;
        for (int i = 0; i < 32; i++) fires[i] += int'(spikes[i]);
        hs++; since = 0;
      end
      if (!busy) break;
      if (cyc >= budget) begin tmo = 1'b1; break; end
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (spikes_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", spikes_valid); end
    vectors++; if (spikes !== 32'h0) begin miscompares++; $display("FAIL reset_spikes: got %h expected 0", spikes); end
    vectors++; if (step_count !== 16'h0) begin miscompares++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (mem_data_out !== 32'h0) begin miscompares++; $display("FAIL reset_mem_out: got %h expected 0", mem_data_out); end
    rst = 1'b0;
  endtask

  task automatic test_host();
    logic [31:0] d;
    rd(8'd5, d);
    vectors++; if (d !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL host_init: got %h expected 7fffffff", d); end
    wr(8'd3, 32'h1234_5678);
    rd(8'd3, d);
    vectors++; if (d !== 32'h1234_5678) begin miscompares++; $display("FAIL host_rdwr: got %h expected 12345678", d); end
    @(negedge clk);
    mem_addr = 8'd3; mem_wen = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_wen = 1'b0;
    vectors++; if (mem_data_out !== 32'h1234_5678) begin miscompares++; $display("FAIL host_rdw_old: got %h expected 12345678", mem_data_out); end
    @(negedge clk);
    vectors++; if (mem_data_out !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL host_rdw_new: got %h expected deadbeef", mem_data_out); end
    wr(8'd40, 32'h5555_5555);
    rd(8'd40, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL host_oor_read: got %h expected 0", d); end
    rd(8'd8, d);
    vectors++; if (d !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL host_oor_alias: got %h expected 7fffffff", d); end
    rd(8'd31, d);
    vectors++; if (d !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL host_last_entry: got %h expected 7fffffff", d); end
  endtask

  task automatic test_zero_prob();
    for (int c = 0; c < 32; c++) wr(8'(c), 32'h0);
    run(16'd4, -1, 400);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL zero_timeout: got %b expected 0", tmo); end
    vectors++; if (hs != 4) begin miscompares++; $display("FAIL zero_handshakes: got %0d expected 4", hs); end
    vectors++; if (acc_or !== 32'h0) begin miscompares++; $display("FAIL zero_spikes: got %h expected 0", acc_or); end
    vectors++; if (step_count !== 16'd4) begin miscompares++; $display("FAIL zero_step_count: got %0d expected 4", step_count); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL zero_done_pulses: got %0d expected 1", dones); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", busy); end
    vectors++; if (first_cyc != 34) begin miscompares++; $display("FAIL zero_latency: got %0d expected 34", first_cyc); end
    vectors++; if (period != 34) begin miscompares++; $display("FAIL zero_period: got %0d expected 34", period); end
  endtask

  task automatic test_single_channel();
    int others;
    wr(8'd3, 32'hFFFF_FFFF);
    run(16'd200, -1, 7200);
    others = 0;
    for (int i = 0; i < 32; i++) if (i != 3) others += fires[i];
    vectors++; if (hs != 200) begin miscompares++; $display("FAIL ch3_handshakes: got %0d expected 200", hs); end
`ifdef REFRACTORY_EN
    vectors++; if (fires[3] != 67) begin miscompares++; $display("FAIL ch3_refractory_fires: got %0d expected 67", fires[3]); end
`else
    vectors++; if (fires[3] < 199) begin miscompares++; $display("FAIL ch3_fires: got %0d expected >=199", fires[3]); end
`endif
    vectors++; if (others != 0) begin miscompares++; $display("FAIL ch3_others: got %0d expected 0", others); end
  endtask

  task automatic test_rate();
    int total;
    for (int c = 0; c < 32; c++) wr(8'(c), 32'h4000_0000);
    run(16'd400, -1, 14000);
    total = 0;
    foreach (fires[i]) total += fires[i];
    vectors++; if (step_count !== 16'd400) begin miscompares++; $display("FAIL rate_step_count: got %0d expected 400", step_count); end
    vectors++; if (total < 2944 || total > 3456) begin miscompares++; $display("FAIL rate_total: got %0d expected 2944..3456", total); end
  endtask

  task automatic test_stall();
    logic [31:0] v0;
    logic ok;
    int cyc;
    for (int c = 0; c < 32; c++) wr(8'(c), 32'h4000_0000);
    @(negedge clk);
    num_steps = 16'd2; spikes_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!spikes_valid && cyc < 100) begin @(negedge clk); cyc++; end
    vectors++; if (spikes_valid !== 1'b1) begin miscompares++; $display("FAIL stall_first_valid: got %b expected 1", spikes_valid); end
    v0 = spikes; ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (spikes !== v0 || spikes_valid !== 1'b1 || step_count !== 16'd0 || busy !== 1'b1) ok = 1'b0;
    end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %b expected 1", ok); end
    spikes_ready = 1'b1; cyc = 0;
    do begin @(negedge clk); cyc++; end while (!spikes_valid && cyc < 100);
    vectors++; if (cyc != 34) begin miscompares++; $display("FAIL stall_resume: got %0d expected 34", cyc); end
    vectors++; if (step_count !== 16'd1) begin miscompares++; $display("FAIL stall_step_count: got %0d expected 1", step_count); end
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    vectors++; if (step_count !== 16'd2 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_finish: got step %0d busy %b expected step 2 busy 0", step_count, busy); end
  endtask

  task automatic test_stop();
    run(16'd0, 4, 400);
    vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL stop_timeout: got %b expected 0", tmo); end
    vectors++; if (hs != 5) begin miscompares++; $display("FAIL stop_handshakes: got %0d expected 5", hs); end
    vectors++; if (step_count !== 16'd5) begin miscompares++; $display("FAIL stop_step_count: got %0d expected 5", step_count); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL stop_done_pulses: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] exp_vec;
    for (int c = 0; c < 32; c++) wr(8'(c), 32'(c) * 32'h0800_0000);
    exp_vec = model_vec();
    @(negedge clk);
    num_steps = 16'd0; spikes_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || spikes_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got busy %b valid %b expected 0 0", busy, spikes_valid); end
    vectors++; if (step_count !== 16'd0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_count: got step %0d done %b expected 0 0", step_count, done); end
    run(16'd1, -1, 200);
    vectors++; if (hs != 1 || dones != 1) begin miscompares++; $display("FAIL rstmid_run: got hs %0d done %0d expected 1 1", hs, dones); end
    vectors++; if (first_vec !== exp_vec) begin miscompares++; $display("FAIL rstmid_reseed_vec: got %h expected %h", first_vec, exp_vec); end
  endtask

  initial begin
    test_reset();
    test_host();
    test_zero_prob();
    test_single_channel();
`ifndef REFRACTORY_EN
    test_rate();
`endif
    test_stall();
    test_stop();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bernoulli_spike_encoder_seq.md
Name: bernoulli_spike_encoder_seq

Overview:
Time-multiplexed, multi-channel Bernoulli spike encoder for the SNN input layer.
- Per-channel firing probabilities live in a host-writable memory.
- One comparator and one LFSR are shared across channels. Channels are scanned sequentially, one evaluation per clock.
- Each scan produces one spike vector per timestep, handed downstream via valid/ready.
- Runs a programmable number of timesteps, or runs free until stopped.

Parameters:
NUM_CHANNELS, 32, number of spike channels (>=2)
PROB_WIDTH, 32, probability word and random word width
ADDR_WIDTH, 8, host address width; must satisfy 2**ADDR_WIDTH >= NUM_CHANNELS
STEP_WIDTH, 16, timestep counter width
LFSR_SEED, 32'hACE1_0001, nonzero LFSR load value (low PROB_WIDTH bits used)
PROB_INIT, 32'h7FFF_FFFF, power-up content of every probability entry
REFRACT_STEPS, 2, refractory length in timesteps (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin run; sampled in IDLE only
stop  in  1  finish current timestep, then end run
num_steps  in  STEP_WIDTH  timesteps per run; 0 = free-running
mem_addr  in  ADDR_WIDTH  host address
mem_wen  in  1  host write enable
mem_data_in  in  PROB_WIDTH  host write data
mem_data_out  out  PROB_WIDTH  host read data, 1-cycle latency
spikes  out  NUM_CHANNELS  spike vector for the completed timestep
spikes_valid  out  1  spikes holds a completed timestep
spikes_ready  in  1  downstream accepts spikes
step_count  out  STEP_WIDTH  timesteps accepted in the current run
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of run

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE; spikes=0; spikes_valid=0; step_count=0; busy=0; done=0; mem_data_out=0; LFSR=LFSR_SEED.
- Reset does not alter the probability memory. Its power-up content is PROB_INIT in every entry.
- Host port:
  - Writes are accepted in every state.
  - Read-during-write to the same address returns the old data.
  - Addresses >= NUM_CHANNELS: writes are ignored, reads return 0.
  - A scan read of a channel and a host write to that channel in the same cycle: the scan uses the old value.
- Firing rule: spike[ch] = (prob[ch] > rnd). rnd is the LFSR output, and the LFSR advances exactly once per channel evaluation.
  - prob=0 never fires.
  - The LFSR is a maximal-length Galois LFSR and never holds 0.
- FSM states:
  - IDLE: on start, clear step_count and go to SCAN.
  - SCAN: channel index c runs 0..NUM_CHANNELS-1, one memory read per cycle. The registered read data is compared one cycle later, and the result is written into the shadow vector bit. After c=NUM_CHANNELS-1 is issued, go to LAST.
  - LAST: evaluate the final channel, copy shadow to spikes, assert spikes_valid, go to HOLD.
  - HOLD: wait for spikes_valid && spikes_ready. On the handshake:
    - drop spikes_valid and increment step_count;
    - if (num_steps!=0 && step_count+1==num_steps) or a stop was latched, go to FIN;
    - else go to SCAN.
  - FIN: pulse done, go to IDLE.
- Latency: start in cycle 0 gives spikes_valid high in cycle NUM_CHANNELS+2. With spikes_ready held high, the valid period is NUM_CHANNELS+2 cycles per timestep.
- spikes and spikes_valid are stable while spikes_valid && !spikes_ready.
- stop is latched while busy and cleared on IDLE entry.
- start while busy is ignored.
- start and stop asserted together in IDLE: the run starts and ends after exactly one timestep.
- step_count wraps modulo 2**STEP_WIDTH in free-running mode.
- rst mid-scan: abandon the timestep. No done pulse, no valid. The LFSR is reseeded.

Optional Feature:
REFRACTORY_EN.
- Defined: each channel carries a refractory counter, width clog2(REFRACT_STEPS+1).
  - A channel that fires loads its counter with REFRACT_STEPS.
  - While its counter is nonzero, the channel's spike is forced to 0 and the counter decrements once per accepted timestep.
  - The LFSR still advances for suppressed channels.
  - Counters clear on rst and on start.
- Undefined: no counters exist and the firing rule applies unmodified.

Decomposition:
- Package bernoulli_enc_pkg holds:
  - the FSM state enum (IDLE, SCAN, LAST, HOLD, FIN);
  - the LFSR tap constants per PROB_WIDTH (8, 16, 32);
  - a function for the refractory counter width.
- One sub-module, lfsr_step: Galois LFSR with clock-enable and synchronous load of LFSR_SEED on rst.

Test Plan:
- Program all probs=0, start with num_steps=4 -> four valid handshakes, all spikes=0, step_count=4, done pulses once, busy low.
- Set prob[3]=all-ones, others 0; run 1000 steps -> channel 3 fires on >=999 steps, all others never fire.
- Set prob[ch]=32'h4000_0000 for all channels; 2000 steps -> per-channel firing rate 0.25±0.03.
- Hold spikes_ready low 10 cycles after the first valid -> spikes constant, no new scan starts, step_count unchanged; the handshake resumes the scan.
- num_steps=0 with stop asserted mid-scan of step 5 -> step 5 completes, done pulses, step_count=5.
- With REFRACTORY_EN, REFRACT_STEPS=2, prob[0]=all-ones -> channel 0 fires at most once in every three consecutive timesteps. Assert rst mid-scan -> busy=0, spikes_valid=0 on the next cycle.
